// File: rtl/scan_mod_counter.sv
// Scan-testable modulo up/down counter with synchronous load, sticky wrap flag
// and a WIDTH+1 bit scan chain (si -> count[0..WIDTH-1] -> ovf -> so).
module scan_mod_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             se,
  input  logic             si,
  input  logic             en,
  input  logic             up_dn,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             tc,
  output logic             so
);

  // MODULUS may equal 2**WIDTH, so range compares use one extra bit.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt;
  logic             wrap;

  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    if ({1'b0, v} <= MAX_EXT) return v;
    else                      return MAX_VAL;
  endfunction

  always_comb begin
    count_nxt = count;
    ovf_nxt   = ovf;
    wrap      = 1'b0;
    if (se) begin
      count_nxt = {count[WIDTH-2:0], si};
      ovf_nxt   = count[WIDTH-1];
    end else begin
      if (ld) begin
        count_nxt = sat_load(ld_val);
      end else if (en) begin
        if (up_dn) begin
          // Out-of-range values left by a scan shift also wrap to zero.
          if ({1'b0, count} >= MAX_EXT) begin
            count_nxt = '0;
            wrap      = 1'b1;
          end else begin
            count_nxt = count + WIDTH'(1);
          end
        end else begin
          if (count == '0) begin
            count_nxt = MAX_VAL;
            wrap      = 1'b1;
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end
      end
      if (clr_ovf) ovf_nxt = 1'b0;
      if (wrap)    ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RST_CNT;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign tc = ~se & ~ld & en & (up_dn ? (count == MAX_VAL) : (count == '0));
  assign so = ovf;

endmodule

// File: tb/tb_scan_mod_counter.sv
// Directed bench for scan_mod_counter: MODULUS=8 and MODULUS=6 instances
// share one stimulus stream; each section checks the instance it targets.
module tb_scan_mod_counter;

  logic       clk = 1'b0;
  logic       rst, se, si, en, up_dn, ld, clr_ovf;
  logic [2:0] ld_val;
  logic [2:0] c8, c6;
  logic       o8, t8, s8, o6, t6, s6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scan_mod_counter #(.WIDTH(3), .MODULUS(8), .RST_VAL(0)) u8 (
    .clk(clk), .rst(rst), .se(se), .si(si), .en(en), .up_dn(up_dn),
    .ld(ld), .ld_val(ld_val), .clr_ovf(clr_ovf),
    .count(c8), .ovf(o8), .tc(t8), .so(s8)
  );

  scan_mod_counter #(.WIDTH(3), .MODULUS(6), .RST_VAL(0)) u6 (
    .clk(clk), .rst(rst), .se(se), .si(si), .en(en), .up_dn(up_dn),
    .ld(ld), .ld_val(ld_val), .clr_ovf(clr_ovf),
    .count(c6), .ovf(o6), .tc(t6), .so(s6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    se = 0; si = 0; en = 0; ld = 0; clr_ovf = 0; up_dn = 1; ld_val = 0;
    rst = 1;
    #1;
    rst = 0;
    #1;
  endtask

  int          c;
  logic        ov;
  logic [3:0]  bits;
  logic [2:0]  so_exp;

  initial begin
    rst = 1; se = 0; si = 0; en = 0; up_dn = 1; ld = 0; ld_val = 0; clr_ovf = 0;
    #3;
    check("rst_count", c8, 0);
    check("rst_ovf", o8, 0);
    check("rst_so", s8, 0);
    step(); step();
    rst = 0;

    // Basic up count 0..7 -> 0 on MODULUS=8
    en = 1; up_dn = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("up_count", c8, k);
      check("up_tc", t8, (k == 7));
      check("up_ovf", o8, 0);
      step();
    end
    check("up_wrap_count", c8, 0);
    check("up_wrap_ovf", o8, 1);
    check("up_wrap_so", s8, 1);

    // Gated enable on MODULUS=6: 6 on, 2 off, twice
    do_reset();
    check("gate_rst", c6, 0);
    c = 0; ov = 0;
    for (int i = 0; i < 16; i++) begin
      en = ((i % 8) < 6);
      #1;
      check("gate_tc", t6, (en && c == 5));
      step();
      if (en) begin
        if (c == 5) begin c = 0; ov = 1; end
        else c++;
      end
      check("gate_count", c6, c);
      check("gate_ovf", o6, ov);
    end
    en = 0; ld = 1; ld_val = 5;
    step();
    ld = 0;
    #1;
    check("hold5_tc", t6, 0);
    step();
    check("hold5_count", c6, 5);

    // Load then count down through the wrap on MODULUS=6
    do_reset();
    ld = 1; ld_val = 3; en = 0;
    step();
    check("ld3_count", c6, 3);
    check("ld3_ovf", o6, 0);
    ld = 0; en = 1; up_dn = 0;
    step(); check("dn_2", c6, 2);
    step(); check("dn_1", c6, 1);
    step(); check("dn_0", c6, 0);
    #1; check("dn_tc", t6, 1);
    step(); check("dn_wrap", c6, 5);
    check("dn_ovf", o6, 1);
    ld = 1; ld_val = 7; en = 0;
    step(); check("ld_sat", c6, 5);
    ld = 1; ld_val = 2; en = 1; up_dn = 1;
    #1; check("ld_tc_mask", t6, 0);
    step(); check("ld_wins", c6, 2);

    // Clear vs wrap collision
    ld = 0; en = 0; clr_ovf = 1;
    step(); check("clr_ovf", o6, 0);
    clr_ovf = 0; ld = 1; ld_val = 5;
    step(); check("ld5", c6, 5);
    ld = 0; en = 1; up_dn = 1; clr_ovf = 1;
    step();
    check("coll_count", c6, 0);
    check("coll_ovf", o6, 1);
    en = 0; clr_ovf = 1;
    step(); check("clr_after", o6, 0);
    clr_ovf = 0;

    // Scan shift on MODULUS=8 with en/ld toggling
    do_reset();
    se = 1;
    bits = 4'b1010; // bit i is the i-th shifted value: 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      si = bits[i]; en = (i % 2 == 1); ld = (i % 2 == 0); ld_val = 6;
      #1; check("scan_tc", t8, 0);
      step();
    end
    check("scan_count", c8, 5);
    check("scan_ovf", o8, 0);
    check("scan_so0", s8, 0);
    si = 0; en = 0; ld = 0;
    so_exp = 3'b101; // next three so bits in order: 1,0,1
    for (int i = 0; i < 3; i++) begin
      step();
      check("scan_so", s8, so_exp[i]);
    end

    // Out-of-range value from scan on MODULUS=6
    do_reset();
    se = 1; si = 1;
    step(); step(); step();
    check("oor_count", c6, 7);
    se = 0; en = 1; up_dn = 0;
    #1; check("oor_dn_tc", t6, 0);
    step();
    check("oor_dn_count", c6, 6);
    check("oor_dn_ovf", o6, 0);
    do_reset();
    se = 1; si = 1;
    step(); step(); step();
    se = 0; en = 1; up_dn = 1;
    #1; check("oor_up_tc", t6, 0);
    step();
    check("oor_up_count", c6, 0);
    check("oor_up_ovf", o6, 1);

    // Async reset in the middle of a shift
    do_reset();
    se = 1; si = 1;
    step(); step();
    check("mid_pre", c8, 3);
    #3; rst = 1;
    #1;
    check("mid_rst_count", c8, 0);
    check("mid_rst_ovf", o8, 0);
    check("mid_rst_so", s8, 0);
    #1; rst = 0;
    step();
    check("mid_resume", c8, 1);
    check("mid_resume_ovf", o8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
